// File: rtl/ccd_line_timing_pkg.sv
// rtl/ccd_line_timing_pkg.sv - shared state encoding and default line timing for the CCD readout
// Contents: state_e (FSM encoding), DEF_* timing/width defaults shared with capture logic.
package ccd_line_timing_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SH   = 3'd1,
    ST_GAP  = 3'd2,
    ST_READ = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam int DEF_SH_WIDTH = 20;
  localparam int DEF_SH_GAP   = 10;
  localparam int DEF_PIX_DIV  = 4;
  localparam int DEF_NUM_PIX  = 512;
  localparam int DEF_IDX_W    = 10;
  localparam int DEF_CNT_W    = 16;

endpackage

// File: rtl/ccd_line_timing_pix_clk_gen.sv
// rtl/ccd_line_timing_pix_clk_gen.sv - gated divide-by-2*DIV clock with rise strobe
// Ports:
//   clk_in, rst_n  : system clock, async active-low reset
//   enable         : run the divider; when low the divider and clock are held at 0
//   clk_out        : divided clock, toggles each time the divider wraps
//   rise_pulse     : one-cycle strobe coincident with clk_out going 0->1
//   toggle_tick    : combinational, high in the cycle before clk_out toggles
module ccd_line_timing_pix_clk_gen #(
  parameter int DIV   = 4,
  parameter int CNT_W = 16
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic enable,
  output logic clk_out,
  output logic rise_pulse,
  output logic toggle_tick
);

  logic [CNT_W-1:0] div_q, div_d;
  logic             clk_q, clk_d;
  logic             rise_q, rise_d;

  assign toggle_tick = enable && (div_q == CNT_W'(DIV - 1));
  assign clk_out     = clk_q;
  assign rise_pulse  = rise_q;

  always_comb begin
    div_d  = div_q;
    clk_d  = clk_q;
    rise_d = 1'b0;
    if (!enable) begin
      div_d = '0;
      clk_d = 1'b0;
    end else if (toggle_tick) begin
      div_d  = '0;
      clk_d  = ~clk_q;
      rise_d = ~clk_q;
    end else begin
      div_d = div_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      clk_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      clk_q  <= clk_d;
      rise_q <= rise_d;
    end
  end

endmodule

// File: rtl/ccd_line_timing.sv
// rtl/ccd_line_timing.sv - CCD line readout sequencer: SH pulse, gap, gated pixel clock, end of line
// Ports:
//   clk_in, rst_n : system clock, async active-low reset
//   line_start    : line strobe; its rising edge starts a line when idle
//   sh_out        : shift-gate pulse
//   pix_clk       : sensor pixel clock, low outside readout
//   pix_valid     : one-cycle strobe per pixel, with pix_clk rising
//   pix_index     : current pixel number, held between strobes
//   busy          : high whenever a line is in progress
//   line_done     : one-cycle end-of-line strobe
//   overrun       : sticky, a line_start edge arrived while busy
module ccd_line_timing
  import ccd_line_timing_pkg::*;
#(
  parameter int SH_WIDTH = DEF_SH_WIDTH,
  parameter int SH_GAP   = DEF_SH_GAP,
  parameter int PIX_DIV  = DEF_PIX_DIV,
  parameter int NUM_PIX  = DEF_NUM_PIX,
  parameter int IDX_W    = DEF_IDX_W,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             line_start,
  output logic             sh_out,
  output logic             pix_clk,
  output logic             pix_valid,
  output logic [IDX_W-1:0] pix_index,
  output logic             busy,
  output logic             line_done,
  output logic             overrun
);

  // One extra bit so the count can reach NUM_PIX even when NUM_PIX == 2**IDX_W.
  localparam int PIX_CNT_W = IDX_W + 1;

  if (NUM_PIX > (1 << IDX_W)) begin : g_bad_num_pix
    $error("ccd_line_timing: NUM_PIX does not fit in IDX_W bits");
  end

  state_e                 state_q, state_d;
  logic                   ls_q, ls_d;
  logic [CNT_W-1:0]       phase_q, phase_d;
  logic [PIX_CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [IDX_W-1:0]       pix_index_q, pix_index_d;
  logic                   overrun_q, overrun_d;

  logic start;
  logic toggle_tick;
  logic pix_rise;

  assign start = line_start & ~ls_q;

  ccd_line_timing_pix_clk_gen #(
    .DIV   (PIX_DIV),
    .CNT_W (CNT_W)
  ) u_pix_clk_gen (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .enable      (state_q == ST_READ),
    .clk_out     (pix_clk),
    .rise_pulse  (pix_valid),
    .toggle_tick (toggle_tick)
  );

  // The divider is about to take pix_clk high: latch the pixel number now so
  // pix_index changes together with pix_valid.
  assign pix_rise = toggle_tick & ~pix_clk;

  always_comb begin
    state_d     = state_q;
    ls_d        = line_start;
    phase_d     = phase_q;
    pix_cnt_d   = pix_cnt_q;
    pix_index_d = pix_index_q;
    overrun_d   = overrun_q | (start & (state_q != ST_IDLE));

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SH;
          phase_d = '0;
        end
      end
      ST_SH: begin
        if (phase_q == CNT_W'(SH_WIDTH - 1)) begin
          state_d = ST_GAP;
          phase_d = '0;
        end else begin
          phase_d = phase_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (phase_q == CNT_W'(SH_GAP - 1)) begin
          state_d = ST_READ;
          phase_d = '0;
        end else begin
          phase_d = phase_q + CNT_W'(1);
        end
      end
      ST_READ: begin
        if (pix_rise) begin
          pix_index_d = pix_cnt_q[IDX_W-1:0];
          pix_cnt_d   = pix_cnt_q + PIX_CNT_W'(1);
        end
        // Leave on the falling toggle after the last pixel so pix_clk ends low.
        if (toggle_tick && pix_clk && (pix_cnt_q == PIX_CNT_W'(NUM_PIX))) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d     = ST_IDLE;
        pix_cnt_d   = '0;
        pix_index_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ls_q        <= 1'b0;
      phase_q     <= '0;
      pix_cnt_q   <= '0;
      pix_index_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ls_q        <= ls_d;
      phase_q     <= phase_d;
      pix_cnt_q   <= pix_cnt_d;
      pix_index_q <= pix_index_d;
      overrun_q   <= overrun_d;
    end
  end

  assign sh_out    = (state_q == ST_SH);
  assign busy      = (state_q != ST_IDLE);
  assign line_done = (state_q == ST_DONE);
  assign pix_index = pix_index_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_ccd_line_timing.sv
// tb/tb_ccd_line_timing.sv - self-checking bench for ccd_line_timing (default and minimal timing)
module tb_ccd_line_timing;

  localparam int NO_LINE = -1000000;
  localparam int L_A     = 20 + 10 + 2 * 4 * 512 + 1;
  localparam int PERIOD  = 5001;

  logic clk = 1'b0;
  logic rst_n;
  logic ls_a, ls_b;

  logic       sh_a, pc_a, pv_a, busy_a, done_a, ovr_a;
  logic [9:0] idx_a;
  logic       sh_b, pc_b, pv_b, busy_b, done_b, ovr_b;
  logic [1:0] idx_b;

  int cyc;
  int n_checks;
  int n_fail;
  int m_t[2];
  logic m_prev[2];
  logic m_ovr[2];
  int pv_count_a;
  int done_cycs[$];

  always #5 clk = ~clk;

  ccd_line_timing u_dut_a (
    .clk_in     (clk),
    .rst_n      (rst_n),
    .line_start (ls_a),
    .sh_out     (sh_a),
    .pix_clk    (pc_a),
    .pix_valid  (pv_a),
    .pix_index  (idx_a),
    .busy       (busy_a),
    .line_done  (done_a),
    .overrun    (ovr_a)
  );

  ccd_line_timing #(
    .SH_WIDTH (1),
    .SH_GAP   (1),
    .PIX_DIV  (1),
    .NUM_PIX  (4),
    .IDX_W    (2),
    .CNT_W    (8)
  ) u_dut_b (
    .clk_in     (clk),
    .rst_n      (rst_n),
    .line_start (ls_b),
    .sh_out     (sh_b),
    .pix_clk    (pc_b),
    .pix_valid  (pv_b),
    .pix_index  (idx_b),
    .busy       (busy_b),
    .line_done  (done_b),
    .overrun    (ovr_b)
  );

  // Expected outputs k cycles after the cycle in which a start was accepted,
  // packed as {sh, pix_clk, pix_valid, busy, line_done, overrun, index[9:0]}.
  function automatic logic [15:0] model_out(input int sw, input int sg, input int pd,
                                            input int np, input int k, input logic ovr);
    int   len;
    int   r;
    int   idx;
    logic sh, pc, pv, bz, dn;
    len = sw + sg + 2 * pd * np + 1;
    sh  = (k >= 1) && (k <= sw);
    bz  = (k >= 1) && (k <= len);
    dn  = (k == len);
    r   = k - (sw + sg + 1);
    pc  = 1'b0;
    pv  = 1'b0;
    idx = 0;
    if (r >= 0 && r < 2 * pd * np) begin
      pc = ((r / pd) % 2) == 1;
      pv = (r % (2 * pd)) == pd;
      if (r >= pd) idx = (r - pd) / (2 * pd);
    end
    if (dn) idx = np - 1;
    return {sh, pc, pv, bz, dn, ovr, idx[9:0]};
  endfunction

  task automatic check_cycle();
    for (int i = 0; i < 2; i++) begin
      logic [15:0] exp_v;
      logic [15:0] obs_v;
      logic        ls;
      if (!rst_n) begin
        m_t[i]    = NO_LINE;
        m_prev[i] = 1'b0;
        m_ovr[i]  = 1'b0;
      end
      if (i == 0) begin
        exp_v = model_out(20, 10, 4, 512, cyc - m_t[0], m_ovr[0]);
        obs_v = {sh_a, pc_a, pv_a, busy_a, done_a, ovr_a, idx_a};
        ls    = ls_a;
      end else begin
        exp_v = model_out(1, 1, 1, 4, cyc - m_t[1], m_ovr[1]);
        obs_v = {sh_b, pc_b, pv_b, busy_b, done_b, ovr_b, 8'd0, idx_b};
        ls    = ls_b;
      end
      n_checks++;
      assert (obs_v === exp_v) else begin
        n_fail++;
        $error("FAIL outputs_%0s cyc=%0d observed=%h expected=%h (sh,pclk,pval,busy,done,ovr,idx)",
               (i == 0) ? "a" : "b", cyc, obs_v, exp_v);
      end
      if (rst_n) begin
        if (ls && !m_prev[i]) begin
          if (exp_v[12]) m_ovr[i] = 1'b1;
          else           m_t[i]   = cyc;
        end
        m_prev[i] = ls;
      end
    end
    if (pv_a) pv_count_a++;
    if (done_a) done_cycs.push_back(cyc);
  endtask

  task automatic run(input int n);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic pulse_a(input int width);
    ls_a = 1'b1;
    run(width);
    ls_a = 1'b0;
  endtask

  initial begin
    int t0;
    int w;
    int cnt;
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    pv_count_a = 0;
    for (int i = 0; i < 2; i++) begin
      m_t[i]    = NO_LINE;
      m_prev[i] = 1'b0;
      m_ovr[i]  = 1'b0;
    end
    rst_n = 1'b0;
    ls_a  = 1'b0;
    ls_b  = 1'b0;
    @(posedge clk);
    #1;

    // Reset state.
    run(3);
    rst_n = 1'b1;
    run($urandom_range(2, 10));

    // Single clean line; 512 pixel strobes expected.
    pv_count_a = 0;
    pulse_a(1);
    run(L_A + 5);
    n_checks++;
    assert (pv_count_a === 512) else begin
      n_fail++;
      $error("FAIL pix_valid_count observed=%0d expected=%0d", pv_count_a, 512);
    end

    // line_start held high for 100 cycles: one line, no overrun.
    pulse_a(100);
    run(L_A + 5 - 100);

    // Second edge 2000 cycles in, then a random stray edge: both overruns.
    pulse_a(1);
    run(1999);
    pulse_a(1);
    run($urandom_range(100, 1500));
    pulse_a($urandom_range(1, 50));
    run(L_A + 10 - 2000);
    // Clean line with overrun still latched.
    pulse_a(1);
    run(L_A + 5);

    // Reset mid-readout at T+1000.
    pulse_a(1);
    run(999);
    rst_n = 1'b0;
    #1;
    n_checks++;
    assert ({sh_a, pc_a, pv_a, busy_a, done_a, ovr_a} === 6'b0) else begin
      n_fail++;
      $error("FAIL async_reset_drop observed=%b expected=%b", {sh_a, pc_a, pv_a, busy_a, done_a, ovr_a}, 6'b0);
    end
    run(2);
    rst_n = 1'b1;
    run(3);
    pulse_a(1);
    run(L_A + 5);

    // Random widths and gaps between lines.
    for (int n = 0; n < 2; n++) begin
      w = $urandom_range(1, 200);
      pulse_a(w);
      run(L_A + $urandom_range(1, 20) - w + 1);
    end

    // Minimal-timing instance: one clean line, then random pulse trains.
    ls_b = 1'b1;
    run(1);
    ls_b = 1'b0;
    run(15);
    for (int n = 0; n < 30; n++) begin
      ls_b = 1'b1;
      run($urandom_range(1, 3));
      ls_b = 1'b0;
      run($urandom_range(0, 14));
    end
    run(15);

    // Counter-driven: zero strobe every PERIOD cycles for three periods.
    rst_n = 1'b0;
    run(2);
    rst_n = 1'b1;
    run(2);
    done_cycs.delete();
    cnt = 0;
    for (int n = 0; n < 3 * PERIOD; n++) begin
      ls_a = (cnt == 0);
      run(1);
      cnt = (cnt == PERIOD - 1) ? 0 : cnt + 1;
    end
    ls_a = 1'b0;
    run(5);
    n_checks++;
    assert (done_cycs.size() === 3) else begin
      n_fail++;
      $error("FAIL line_done_count observed=%0d expected=%0d", done_cycs.size(), 3);
    end
    if (done_cycs.size() == 3) begin
      for (int n = 1; n < 3; n++) begin
        t0 = done_cycs[n] - done_cycs[n-1];
        n_checks++;
        assert (t0 === PERIOD) else begin
          n_fail++;
          $error("FAIL line_done_spacing observed=%0d expected=%0d", t0, PERIOD);
        end
      end
    end
    n_checks++;
    assert (ovr_a === 1'b0) else begin
      n_fail++;
      $error("FAIL counter_overrun observed=%b expected=%b", ovr_a, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
